// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core pipeline.
// Holds the NOP encoding, opcode[6:2] codes, fetch states and the IF/ID bundle.
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for a fetched instruction.
// It parks the response that arrives while the pipeline is stalled.
module fetch_skid_buf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] dout,
    output logic            valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC, IMEM handshake, stall/flush handling.
// Optional perf counters are built in when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_stall_o,
    output logic [31:0] perf_bubble_o,
`endif
    input  logic        hazard_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [4:0]  ifid_rs1_o,
    output logic [4:0]  ifid_rs2_o,
    output logic [4:0]  ifid_rd_o,
    output logic [4:0]  ifid_opcode_o
);

    import core_pkg::*;

    fetch_state_t state;
    if_id_t       ifid;
    logic [31:0]  pc;
    logic [31:0]  drain_addr;
    logic [31:0]  tgt;
    logic [31:0]  skid_data;
    logic         skid_vld;
    logic         skid_load;
    logic         skid_clear;
    logic         gap;

    assign tgt = {redirect_pc_i[31:2], 2'b00};

    assign skid_load = !gap && state == S_FETCH && !redirect_i
                     && hazard_i && imem_ready_i;
    assign skid_clear = !gap && state == S_HOLD
                      && (redirect_i || !hazard_i);

    assign imem_req_o  = !gap && state != S_HOLD;
    assign imem_addr_o = (state == S_DRAIN) ? drain_addr : pc;

    assign ifid_valid_o  = ifid.valid;
    assign ifid_pc_o     = ifid.pc;
    assign ifid_instr_o  = ifid.instr;
    assign ifid_rs1_o    = ifid.instr[19:15];
    assign ifid_rs2_o    = ifid.instr[24:20];
    assign ifid_rd_o     = ifid.instr[11:7];
    assign ifid_opcode_o = ifid.instr[6:2];

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (imem_rdata_i),
        .dout  (skid_data),
        .valid (skid_vld)
    );

    // gap blanks the first cycle after reset so a stale response is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
            gap        <= 1'b1;
            ifid.valid <= 1'b0;
            ifid.pc    <= '0;
            ifid.instr <= NOP_INSTR;
        end else if (gap) begin
            gap <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (redirect_i) begin
                        pc         <= tgt;
                        ifid.valid <= 1'b0;
                        ifid.instr <= NOP_INSTR;
                        if (!imem_ready_i) begin
                            state      <= S_DRAIN;
                            drain_addr <= pc;
                        end
                    end else if (hazard_i) begin
                        if (imem_ready_i)
                            state <= S_HOLD;
                    end else if (imem_ready_i) begin
                        ifid.valid <= 1'b1;
                        ifid.pc    <= pc;
                        ifid.instr <= imem_rdata_i;
                        pc         <= pc + 32'd4;
                    end else begin
                        ifid.valid <= 1'b0;
                        ifid.instr <= NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        pc         <= tgt;
                        ifid.valid <= 1'b0;
                        ifid.instr <= NOP_INSTR;
                        state      <= S_FETCH;
                    end else if (!hazard_i && skid_vld) begin
                        ifid.valid <= 1'b1;
                        ifid.pc    <= pc;
                        ifid.instr <= skid_data;
                        pc         <= pc + 32'd4;
                        state      <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (redirect_i)
                        pc <= tgt;
                    if (imem_ready_i)
                        state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic bubble;

    assign bubble = !gap && (redirect_i
                  || (state == S_FETCH && !hazard_i && !imem_ready_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_o  <= '0;
            perf_bubble_o <= '0;
        end else begin
            if (hazard_i && perf_stall_o != '1)
                perf_stall_o <= perf_stall_o + 32'd1;
            if (bubble && perf_bubble_o != '1)
                perf_bubble_o <= perf_bubble_o + 32'd1;
        end
    end
`endif

endmodule
